// File: rtl/text_console_writer_if.sv
// rtl/text_console_writer_if.sv - byte stream and text memory port A bundle
// Purpose : groups the incoming byte handshake and the port A write bus.
// Signals : char_in/char_valid/char_ready - byte stream (valid/ready)
//           mem_we/mem_addr/mem_data      - text memory port A (wea/addra/dina)
// Modports: master - byte source / memory observer
//           slave  - the console writer
interface text_console_writer_if;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data;

    modport master (
        output char_in, char_valid,
        input  char_ready, mem_we, mem_addr, mem_data
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, mem_we, mem_addr, mem_data
    );
endinterface

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to text framebuffer port A writer
// Purpose : keeps a cursor over an 80x30 text screen, writes printable bytes,
//           interprets CR/LF/BS/FF and blanks the screen or the new line.
// Ports   : i_clk, i_rst (async, active high)
//           bus          - slave side of text_console_writer_if
//           o_cursor_col - current column 0..COLS-1
//           o_cursor_row - current row 0..ROWS-1
//           o_busy       - high during a screen or line clear
module text_console_writer #(
    parameter int         COLS  = 80,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    text_console_writer_if.slave  bus,
    output logic [6:0]            o_cursor_col,
    output logic [4:0]            o_cursor_row,
    output logic                  o_busy
);
    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);

    typedef enum logic [1:0] {
        S_CLR_SCREEN,
        S_IDLE,
        S_WRITE,
        S_CLR_LINE
    } state_t;

    state_t      r_state;
    logic [6:0]  r_col;
    logic [4:0]  r_row;
    logic [7:0]  r_byte;
    logic        r_adv;     // WRITE advances the cursor (printable) or not (BS)
    logic [11:0] r_cnt;     // next cell / offset to blank during clears
    logic        r_we;
    logic [11:0] r_addr;
    logic [7:0]  r_data;
    logic        r_ready;
    logic        r_busy;

    logic        w_accept;
    logic [4:0]  w_next_row;
    logic [11:0] w_cur_addr;
    logic [11:0] w_bs_addr;
    logic [11:0] w_row_base;
    logic [11:0] w_next_base;

    function automatic logic [11:0] cell_addr(input logic [6:0] c, input logic [4:0] r);
        return {5'd0, c} + {7'd0, r} * 12'(COLS);
    endfunction

    // Acceptance is qualified by the registered ready the upstream sees.
    assign w_accept    = (r_state == S_IDLE) && r_ready && bus.char_valid;
    assign w_next_row  = (r_row == 5'(ROWS - 1)) ? 5'd0 : r_row + 5'd1;
    assign w_cur_addr  = cell_addr(r_col, r_row);
    assign w_bs_addr   = cell_addr(r_col - 7'd1, r_row);
    assign w_row_base  = cell_addr(7'd0, r_row);
    assign w_next_base = cell_addr(7'd0, w_next_row);

    // Outputs are registered from the state being entered, so each write is
    // visible on the bus in the cycle that state occupies.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_CLR_SCREEN;
            r_col   <= '0;
            r_row   <= '0;
            r_byte  <= BLANK;
            r_adv   <= 1'b0;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_data  <= BLANK;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                S_CLR_SCREEN: begin
                    r_we    <= 1'b1;
                    r_addr  <= r_cnt;
                    r_data  <= BLANK;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b1;
                    if (r_cnt == LAST_CELL) begin
                        r_cnt   <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 12'd1;
                    end
                end

                S_IDLE: begin
                    r_we    <= 1'b0;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        if (bus.char_in >= 8'h20 && bus.char_in <= 8'h7E) begin
                            r_byte  <= bus.char_in;
                            r_adv   <= 1'b1;
                            r_we    <= 1'b1;
                            r_addr  <= w_cur_addr;
                            r_data  <= bus.char_in;
                            r_ready <= 1'b0;
                            r_state <= S_WRITE;
                        end else begin
                            case (bus.char_in)
                                8'h0D: r_col <= '0;
                                8'h0A: begin
                                    r_col   <= '0;
                                    r_row   <= w_next_row;
                                    r_we    <= 1'b1;
                                    r_addr  <= w_next_base;
                                    r_data  <= BLANK;
                                    r_cnt   <= 12'd1;
                                    r_ready <= 1'b0;
                                    r_busy  <= 1'b1;
                                    r_state <= S_CLR_LINE;
                                end
                                8'h08: begin
                                    if (r_col != 7'd0) begin
                                        r_col   <= r_col - 7'd1;
                                        r_byte  <= BLANK;
                                        r_adv   <= 1'b0;
                                        r_we    <= 1'b1;
                                        r_addr  <= w_bs_addr;
                                        r_data  <= BLANK;
                                        r_ready <= 1'b0;
                                        r_state <= S_WRITE;
                                    end
                                end
                                8'h0C: begin
                                    r_cnt   <= '0;
                                    r_ready <= 1'b0;
                                    r_busy  <= 1'b1;
                                    r_state <= S_CLR_SCREEN;
                                end
                                default: ;
                            endcase
                        end
                    end
                end

                S_WRITE: begin
                    if (r_adv && r_col == 7'(COLS - 1)) begin
                        r_col   <= '0;
                        r_row   <= w_next_row;
                        r_we    <= 1'b1;
                        r_addr  <= w_next_base;
                        r_data  <= BLANK;
                        r_cnt   <= 12'd1;
                        r_busy  <= 1'b1;
                        r_state <= S_CLR_LINE;
                    end else begin
                        if (r_adv) begin
                            r_col <= r_col + 7'd1;
                        end
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end

                S_CLR_LINE: begin
                    if (r_cnt == 12'(COLS)) begin
                        r_we    <= 1'b0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_we   <= 1'b1;
                        r_addr <= w_row_base + r_cnt;
                        r_data <= BLANK;
                        r_cnt  <= r_cnt + 12'd1;
                    end
                end

                default: r_state <= S_CLR_SCREEN;
            endcase
        end
    end

    assign bus.char_ready = r_ready;
    assign bus.mem_we     = r_we;
    assign bus.mem_addr   = r_addr;
    assign bus.mem_data   = r_data;
    assign o_cursor_col   = r_col;
    assign o_cursor_row   = r_row;
    assign o_busy         = r_busy;
endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - scoreboard bench for text_console_writer
module tb_text_console_writer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    text_console_writer_if bus();

    text_console_writer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .bus          (bus),
        .o_cursor_col (cursor_col),
        .o_cursor_row (cursor_row),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int d;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  errors   = 0;
    int  n_writes = 0;
    int  m_col    = 0;
    int  m_row    = 0;
    bit  done     = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: screen cells are col + row*80, 2400 cells total.
    function automatic void push_wr(input int a, input int d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endfunction

    function automatic void push_row_clear(input int r);
        for (int c = 0; c < 80; c++) push_wr(r * 80 + c, 32);
    endfunction

    function automatic void push_screen_clear();
        for (int i = 0; i < 2400; i++) push_wr(i, 32);
    endfunction

    function automatic void model_byte(input int b);
        if (b >= 32 && b <= 126) begin
            push_wr(m_row * 80 + m_col, b);
            m_col++;
            if (m_col == 80) begin
                m_col = 0;
                m_row = (m_row + 1) % 30;
                push_row_clear(m_row);
            end
        end else if (b == 13) begin
            m_col = 0;
        end else if (b == 10) begin
            m_col = 0;
            m_row = (m_row + 1) % 30;
            push_row_clear(m_row);
        end else if (b == 8) begin
            if (m_col > 0) begin
                m_col--;
                push_wr(m_row * 80 + m_col, 32);
            end
        end else if (b == 12) begin
            push_screen_clear();
            m_col = 0;
            m_row = 0;
        end
    endfunction

    // Monitor: every write on port A must be the next expected one.
    initial begin
        wr_t e;
        while (!done) begin
            @(negedge clk);
            if (!rst && bus.mem_we) begin
                n_writes++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %0d, none expected",
                             bus.mem_addr, bus.mem_data);
                end else begin
                    e = exp_q.pop_front();
                    if (int'(bus.mem_addr) != e.a || int'(bus.mem_data) != e.d ||
                        bus.mem_addr > 12'd2399) begin
                        errors++;
                        $display("FAIL write: addr %0d data %0d expected addr %0d data %0d",
                                 bus.mem_addr, bus.mem_data, e.a, e.d);
                    end
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [7:0] b);
        int t = 0;
        bus.char_in    = b;
        bus.char_valid = 1'b1;
        while (!bus.char_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!bus.char_ready) begin
            chk("send_timeout", 0, 1);
            bus.char_valid = 1'b0;
            return;
        end
        model_byte(int'(b));
        @(negedge clk);
        bus.char_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (!bus.char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.char_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic send_wait(input logic [7:0] b);
        int n;
        send(b);
        wait_idle(n);
    endtask

    task automatic chk_cursor(input string name);
        chk({name, "_col"}, int'(cursor_col), m_col);
        chk({name, "_row"}, int'(cursor_row), m_row);
        chk({name, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic move_to(input int c, input int r);
        send_wait(8'h0D);
        while (m_row != r) send_wait(8'h0A);
        for (int i = 0; i < c; i++) send_wait(8'h20);
    endtask

    initial begin
        int n;
        int w0;
        int sel;
        logic [7:0] b;
        bus.char_in    = 8'h00;
        bus.char_valid = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_mem_we", int'(bus.mem_we), 0);
        chk("rst_mem_addr", int'(bus.mem_addr), 0);
        chk("rst_mem_data", int'(bus.mem_data), 32);
        chk("rst_char_ready", int'(bus.char_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_col", int'(cursor_col), 0);
        chk("rst_row", int'(cursor_row), 0);

        push_screen_clear();
        rst = 1'b0;
        wait_idle(n);
        chk_cursor("after_clear");
        chk("clear_write_count", n_writes, 2400);

        send(8'h41);
        wait_idle(n);
        chk("ready_latency", n, 1);
        chk_cursor("after_A");

        move_to(79, 3);
        send_wait(8'h5A);
        chk_cursor("wrap_Z");

        move_to(5, 29);
        send_wait(8'h0A);
        chk_cursor("lf_wrap");

        move_to(5, 2);
        w0 = n_writes;
        send_wait(8'h0D);
        repeat (2) @(negedge clk);
        chk("cr_no_write", n_writes, w0);
        chk_cursor("cr");

        move_to(3, 1);
        send_wait(8'h08);
        chk_cursor("bs");
        move_to(0, 1);
        w0 = n_writes;
        send_wait(8'h08);
        repeat (2) @(negedge clk);
        chk("bs_col0_no_write", n_writes, w0);
        chk_cursor("bs_col0");

        send_wait(8'h48);
        send_wait(8'h49);
        send_wait(8'h0C);
        chk_cursor("ff");

        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 99);
            if (sel < 60)      b = 8'($urandom_range(32, 126));
            else if (sel < 70) b = 8'h0D;
            else if (sel < 80) b = 8'h0A;
            else if (sel < 90) b = 8'h08;
            else if (sel < 92) b = 8'h0C;
            else               b = 8'($urandom_range(0, 255));
            send(b);
            if ($urandom_range(0, 3) == 0) begin
                wait_idle(n);
                chk_cursor("rand");
            end
        end
        wait_idle(n);
        chk_cursor("rand_end");

        move_to(10, 5);
        send(8'h0A);
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midline_rst_we", int'(bus.mem_we), 0);
        chk("midline_rst_busy", int'(busy), 1);
        exp_q.delete();
        m_col = 0;
        m_row = 0;
        push_screen_clear();
        repeat (2) @(negedge clk);
        w0 = n_writes;
        rst = 1'b0;
        wait_idle(n);
        chk("reclear_count", n_writes - w0, 2400);
        chk_cursor("reclear");

        done = 1;
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
